imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory of the pipelined core. Accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and drives a single-cycle write port into instruction memory at word-aligned byte addresses starting at 0. Holds the core in reset until the image is fully written, then releases it. It sits between the host link (UART/JTAG byte source) and the instruction memory write port.

## Interface
- DEPTH_WORDS, 4096, instruction memory depth in words (2**12); max accepted word count
- clk_i  input  1  clock
- rst_ni  input  1  synchronous, active-low reset
- byte_i  input  8  incoming stream byte
- byte_valid_i  input  1  byte_i valid
- byte_ready_o  output  1  loader can accept a byte this cycle
- imem_we_o  output  1  instruction memory write enable, one-cycle pulse per word
- imem_addr_o  output  32  byte address of write; always word-aligned, bits [1:0] = 0
- imem_wdata_o  output  32  word to write
- cpu_rst_no  output  1  active-low reset to core; low while loading
- done_o  output  1  image fully written (sticky)
- error_o  output  1  illegal header (sticky)

## Operation
- Stream format: 2-byte word count N (little-endian, first byte = N[7:0]), then 4·N data bytes, each word little-endian (first byte → wdata[7:0]).
- Byte transfer occurs on a rising edge with byte_valid_i && byte_ready_o; no other byte is consumed.
- States: LEN0, LEN1, DATA, WRITE, DONE, ERR.
- LEN0: ready=1; on transfer latch N[7:0] → LEN1.
- LEN1: ready=1; on transfer latch N[15:8]; if N==0 or N>DEPTH_WORDS → ERR, else → DATA with byte index 0, word count 0, address 0.
- DATA: ready=1; on transfer store byte at lane index, index++ (2-bit, wraps); on the 4th byte → WRITE.
- WRITE: ready=0; imem_we_o=1 with assembled word and current address; address += 4, word count++; if word count reaches N → DONE, else → DATA.
- DONE: ready=0, done_o=1, cpu_rst_no=1; stays until rst_ni.
- ERR: ready=0, error_o=1, cpu_rst_no=0; stays until rst_ni.
- Word count and length compare use 16-bit unsigned arithmetic; address is 32-bit, never exceeds 4·(DEPTH_WORDS−1).

## Timing
- Reset (rst_ni=0 at posedge): state ← LEN0; imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_rst_no=0, done_o=0, error_o=0, byte_ready_o=0 while rst_ni low.
- byte_ready_o decoded from state; goes 1 in the first cycle after rst_ni deasserts.
- imem_we_o/addr/wdata are registered: write pulse occurs exactly one cycle after the 4th byte of a word is accepted; pulse width 1 cycle; addr/wdata hold until next write.
- Throughput: max one word per 5 cycles (4 byte cycles + 1 WRITE bubble).
- cpu_rst_no and done_o rise together one cycle after the last write pulse (registered from DONE entry).
- byte_valid_i gaps: state and partial word hold indefinitely; no timeout.
- byte_valid_i asserted in WRITE/DONE/ERR: ignored, byte not consumed.
- Reset mid-load: partial word and counters discarded; next stream restarts at LEN0, address 0; core stays in reset.

## Structure
- Package imem_loader_pkg: state enum (LEN0, LEN1, DATA, WRITE, DONE, ERR), DEPTH_WORDS default, 16-bit count type.
- One sub-module: byte_packer (4-lane little-endian shift/assemble register with 2-bit lane index, clear input); FSM, counters and write-port registers live in imem_loader.

## Test plan
- N=1, bytes 01 00 EF BE AD DE → single write addr 0x0, wdata 0xDEADBEEF; done_o=1, cpu_rst_no=1 one cycle later.
- N=3, words 0x00000013, 0x00100093, 0x00208113 with random valid gaps → writes at 0x0, 0x4, 0x8 in order with matching data; byte_ready_o=0 during each WRITE cycle.
- Header 00 00 (N=0) → error_o=1, no imem_we_o pulse, cpu_rst_no stays 0, byte_ready_o=0.
- Header 01 10 (N=4097) → ERR; N=4096 → 4096 writes, last at 0x3FFC, then DONE.
- Reset asserted after 2 data bytes of word 1 → all outputs at reset values; new stream N=1 writes addr 0x0 with only new bytes.
- byte_valid_i held high after DONE → no further transfers or writes; done_o stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t          : loader FSM states
//   wcount_t         : 16-bit unsigned word count (header length, words written)
//   DEPTH_WORDS_DEF  : default instruction memory depth in words
//   len_ok()         : header legality check (1..depth words)
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   localparam int unsigned DEPTH_WORDS_DEF = 4096;

   typedef logic [15:0] wcount_t;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // A header is legal when it asks for at least one word and no more than
   // the memory can hold.
   function automatic logic len_ok(input wcount_t n, input int unsigned depth);
      return (n != 16'd0) && ({16'd0, n} <= depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Byte-stream handshake plus instruction-memory write port of the loader.
//   byte_i        : incoming stream byte           (host   -> loader)
//   byte_valid_i  : byte_i valid                   (host   -> loader)
//   byte_ready_o  : loader accepts a byte          (loader -> host)
//   imem_we_o     : one-cycle write enable         (loader -> memory)
//   imem_addr_o   : word-aligned byte address      (loader -> memory)
//   imem_wdata_o  : write data                     (loader -> memory)
// Modports: master = loader side, slave = host/memory side.
// -----------------------------------------------------------------------------
interface imem_loader_if;

   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic        imem_we_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_wdata_o;

   modport master (
      input  byte_i,
      input  byte_valid_i,
      output byte_ready_o,
      output imem_we_o,
      output imem_addr_o,
      output imem_wdata_o
   );

   modport slave (
      output byte_i,
      output byte_valid_i,
      input  byte_ready_o,
      input  imem_we_o,
      input  imem_addr_o,
      input  imem_wdata_o
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
// Four-lane little-endian word assembler. Each accepted byte lands in the lane
// selected by a 2-bit index, which then advances and wraps after lane 3.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   i_clear      : restart at lane 0 with all lanes zeroed
//   i_en         : store i_byte in the current lane this cycle
//   i_byte       : byte to store
//   o_lane       : lane the next byte will go to
//   o_word_next  : assembled word including the byte being stored this cycle,
//                  so the final byte of a word is usable without a wait state
// -----------------------------------------------------------------------------
module imem_loader_byte_packer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        i_clear,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic [1:0]  o_lane,
   output logic [31:0] o_word_next
);

   logic [1:0] r_lane;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || i_clear) begin
         r_lane <= 2'd0;
      end else if (i_en) begin
         r_lane <= r_lane + 2'd1;
      end
   end

   assign o_lane = r_lane;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_byte;
         logic       w_hit;

         assign w_hit = i_en && (r_lane == 2'(gi));

         always_ff @(posedge clk_i) begin
            if (!rst_ni || i_clear) begin
               r_byte <= 8'd0;
            end else if (w_hit) begin
               r_byte <= i_byte;
            end
         end

         assign o_word_next[8*gi +: 8] = w_hit ? i_byte : r_byte;
      end
   endgenerate

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time instruction memory writer. Consumes a length-prefixed byte stream
// (16-bit LE word count, then 4*N bytes, words LE), writes each word to
// instruction memory at byte addresses 0, 4, 8, ... and keeps the core in
// reset until the whole image is written.
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   bus         : imem_loader_if.master (byte handshake + memory write port)
//   cpu_rst_no  : active-low core reset, released once the image is written
//   done_o      : image fully written (sticky until reset)
//   error_o     : illegal header length (sticky until reset)
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   imem_loader_if.master bus,
   output logic          cpu_rst_no,
   output logic          done_o,
   output logic          error_o
);

   state_t      r_state;
   state_t      w_state_next;
   wcount_t     r_len;
   wcount_t     r_word_cnt;
   wcount_t     w_len_full;
   logic [31:0] r_next_addr;
   logic [31:0] r_imem_addr;
   logic [31:0] r_imem_wdata;
   logic        r_imem_we;
   logic        r_done;
   logic        r_error;
   logic        w_ready;
   logic        w_xfer;
   logic        w_pack_clr;
   logic        w_pack_en;
   logic        w_last_byte;
   logic        w_last_word;
   logic [1:0]  w_lane;
   logic [31:0] w_word_next;

   // Ready is a pure state decode, forced low while reset is held so no byte
   // can be taken during reset.
   assign w_ready = rst_ni &&
                    ((r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA));
   assign w_xfer  = bus.byte_valid_i && w_ready;

   // Full length as it will be once the high header byte is latched.
   assign w_len_full  = {bus.byte_i, r_len[7:0]};
   assign w_last_word = (r_word_cnt + 16'd1) == r_len;

   imem_loader_byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_clear     (w_pack_clr),
      .i_en        (w_pack_en),
      .i_byte      (bus.byte_i),
      .o_lane      (w_lane),
      .o_word_next (w_word_next)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_LEN0;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pack_clr   = 1'b0;
      w_pack_en    = 1'b0;
      w_last_byte  = 1'b0;
      case (r_state)
         S_LEN0: begin
            if (w_xfer) w_state_next = S_LEN1;
         end
         S_LEN1: begin
            if (w_xfer) begin
               if (len_ok(w_len_full, DEPTH_WORDS)) begin
                  w_state_next = S_DATA;
                  w_pack_clr   = 1'b1;
               end else begin
                  w_state_next = S_ERR;
               end
            end
         end
         S_DATA: begin
            if (w_xfer) begin
               w_pack_en = 1'b1;
               if (w_lane == 2'd3) begin
                  w_last_byte  = 1'b1;
                  w_state_next = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            w_state_next = w_last_word ? S_DONE : S_DATA;
         end
         S_DONE:  w_state_next = S_DONE;
         S_ERR:   w_state_next = S_ERR;
         default: w_state_next = S_LEN0;
      endcase
   end

   // Write-port registers are loaded on the edge that takes the 4th byte, so
   // the pulse is visible during the WRITE cycle that follows.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_len        <= '0;
         r_word_cnt   <= '0;
         r_next_addr  <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         r_done    <= (w_state_next == S_DONE);
         r_error   <= (w_state_next == S_ERR);
         if ((r_state == S_LEN0) && w_xfer) begin
            r_len[7:0] <= bus.byte_i;
         end
         if ((r_state == S_LEN1) && w_xfer) begin
            r_len[15:8] <= bus.byte_i;
            r_word_cnt  <= '0;
            r_next_addr <= '0;
         end
         if (w_last_byte) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_next_addr;
            r_imem_wdata <= w_word_next;
         end
         // Counters stop at the final word so the address never steps past
         // the last memory location.
         if ((r_state == S_WRITE) && !w_last_word) begin
            r_word_cnt  <= r_word_cnt + 16'd1;
            r_next_addr <= r_next_addr + 32'd4;
         end
      end
   end

   assign bus.byte_ready_o = w_ready;
   assign bus.imem_we_o    = r_imem_we;
   assign bus.imem_addr_o  = r_imem_addr;
   assign bus.imem_wdata_o = r_imem_wdata;
   assign cpu_rst_no       = r_done;
   assign done_o           = r_done;
   assign error_o          = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Drives length-prefixed images into imem_loader and checks every memory
// write against expectations queued by the stimulus side.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int unsigned DEPTH = 4096;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic cpu_rst_no;
   logic done_o;
   logic error_o;

   imem_loader_if bus ();

   imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .bus        (bus),
      .cpu_rst_no (cpu_rst_no),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_mis = 0;
   wr_t         sb[$];
   logic [31:0] words[$];
   int          last_we_cyc = -10;
   logic        prev_done = 1'b0;
   bit          aborted = 1'b0;
   wr_t         mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse pops the oldest expected write.
   always @(negedge clk_i) begin
      if (bus.imem_we_o === 1'b1) begin
         $display("write addr=%08h data=%08h cyc=%0d", bus.imem_addr_o, bus.imem_wdata_o, cyc);
         check("ready_low_in_write", 32'(bus.byte_ready_o), 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_write: got addr %h data %h, required no write",
                     bus.imem_addr_o, bus.imem_wdata_o);
         end else begin
            mon_e = sb.pop_front();
            check("wr_addr", bus.imem_addr_o, mon_e.addr);
            check("wr_data", bus.imem_wdata_o, mon_e.data);
            check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
         last_we_cyc = cyc;
      end
      if (done_o === 1'b1 && prev_done !== 1'b1) begin
         check("done_after_last_write", 32'(cyc - last_we_cyc), 32'd1);
      end
      prev_done = done_o;
   end

   // Offer one byte after 'gap' idle cycles; enters and leaves on a negedge.
   // When the byte completes a word, the expected write is queued for the
   // cycle right after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                            input logic [31:0] addr, input logic [31:0] data);
      int waited = 0;
      if (aborted) return;
      for (int i = 0; i < gap; i++) begin
         bus.byte_valid_i = 1'b0;
         @(negedge clk_i);
      end
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = b;
      while (bus.byte_ready_o !== 1'b1 && waited < 50) begin
         @(negedge clk_i);
         waited++;
      end
      if (bus.byte_ready_o !== 1'b1) begin
         n_cmp++;
         n_mis++;
         $display("FAIL ready_timeout: byte %h still not accepted after %0d cycles, required acceptance",
                  b, waited);
         aborted = 1'b1;
         bus.byte_valid_i = 1'b0;
         return;
      end
      if (push) sb.push_back('{addr, data, cyc + 1});
      @(negedge clk_i);
      bus.byte_valid_i = 1'b0;
   endtask

   // Reference model: header = N little-endian, then each word's bytes LSB
   // first; word i lands at byte address 4*i. Illegal N sends header only.
   task automatic run_stream(input int unsigned n, input int maxgap);
      logic [7:0]  b;
      logic [15:0] n16;
      bit          legal;
      n16   = n[15:0];
      legal = (n != 0) && (n <= DEPTH);
      send_byte(n16[7:0], $urandom_range(maxgap, 0), 1'b0, 32'd0, 32'd0);
      send_byte(n16[15:8], $urandom_range(maxgap, 0), 1'b0, 32'd0, 32'd0);
      if (legal) begin
         for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
               b = 8'(words[i] >> (8 * k));
               send_byte(b, $urandom_range(maxgap, 0), k == 3, 32'(4 * i), words[i]);
            end
         end
      end
   endtask

   task automatic make_words(input int unsigned n);
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back($urandom());
   endtask

   task automatic wait_end(input string name, input int limit);
      int t = 0;
      while (done_o !== 1'b1 && error_o !== 1'b1 && t < limit) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= limit) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s_end_timeout: no done/error after %0d cycles, required one", name, limit);
      end
      repeat (3) @(negedge clk_i);
   endtask

   task automatic check_end(input string name, input bit exp_done);
      check({name, "_done"},    32'(done_o),           32'(exp_done));
      check({name, "_cpu_rst"}, 32'(cpu_rst_no),       32'(exp_done));
      check({name, "_error"},   32'(error_o),          32'(!exp_done));
      check({name, "_ready"},   32'(bus.byte_ready_o), 32'd0);
      check({name, "_drained"}, 32'(sb.size()),        32'd0);
   endtask

   task automatic apply_reset();
      rst_ni           = 1'b0;
      bus.byte_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_we",      32'(bus.imem_we_o),    32'd0);
      check("rst_addr",    bus.imem_addr_o,       32'd0);
      check("rst_wdata",   bus.imem_wdata_o,      32'd0);
      check("rst_cpu_rst", 32'(cpu_rst_no),       32'd0);
      check("rst_done",    32'(done_o),           32'd0);
      check("rst_error",   32'(error_o),          32'd0);
      check("rst_ready",   32'(bus.byte_ready_o), 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("ready_after_rst", 32'(bus.byte_ready_o), 32'd1);
   endtask

   initial begin
      bus.byte_i       = 8'd0;
      bus.byte_valid_i = 1'b0;
      @(negedge clk_i);

      // Single word, back-to-back bytes.
      apply_reset();
      words.delete();
      words.push_back(32'hDEADBEEF);
      run_stream(1, 0);
      wait_end("n1", 40);
      check_end("n1", 1'b1);

      // Three words with random valid gaps.
      apply_reset();
      words.delete();
      words.push_back(32'h00000013);
      words.push_back(32'h00100093);
      words.push_back(32'h00208113);
      run_stream(3, 3);
      wait_end("n3", 200);
      check_end("n3", 1'b1);

      // Zero-length header.
      apply_reset();
      run_stream(0, 0);
      wait_end("n0", 40);
      check_end("n0", 1'b0);

      // One word beyond memory depth.
      apply_reset();
      run_stream(DEPTH + 1, 0);
      wait_end("n4097", 40);
      check_end("n4097", 1'b0);

      // A few random images.
      for (int r = 0; r < 3; r++) begin
         int unsigned n;
         n = $urandom_range(8, 1);
         apply_reset();
         make_words(n);
         run_stream(n, 2);
         wait_end("rand", 400);
         check_end("rand", 1'b1);
      end

      // Full memory: last write lands at 0x3FFC.
      apply_reset();
      make_words(DEPTH);
      run_stream(DEPTH, 0);
      wait_end("full", 30000);
      check_end("full", 1'b1);

      // Reset after two data bytes of the first word, then a fresh image.
      apply_reset();
      send_byte(8'h02, 0, 1'b0, 32'd0, 32'd0);
      send_byte(8'h00, 0, 1'b0, 32'd0, 32'd0);
      send_byte(8'h11, 0, 1'b0, 32'd0, 32'd0);
      send_byte(8'h22, 0, 1'b0, 32'd0, 32'd0);
      apply_reset();
      words.delete();
      words.push_back(32'hCAFEF00D);
      run_stream(1, 1);
      wait_end("midrst", 60);
      check_end("midrst", 1'b1);

      // Valid held high after completion: nothing may be taken or written.
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         check("post_done_ready", 32'(bus.byte_ready_o), 32'd0);
      end
      bus.byte_valid_i = 1'b0;
      @(negedge clk_i);
      check("post_done_done",    32'(done_o),     32'd1);
      check("post_done_drained", 32'(sb.size()),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
